// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling RS-232 receiver with configurable width and parity,
// false-start rejection, framing/parity/break detection, and a show-ahead RX FIFO
// with a sticky overflow flag. Timing advances on a fractional-accumulator tick.
module uart_rx_fifo #(
   parameter int ClkFrequency = 25000000,
   parameter int Baud         = 115200,
   parameter int Oversampling = 16,
   parameter int DataBits     = 8,
   parameter int Parity       = 0,
   parameter int Depth        = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       RxD,
   input  logic                       rd_en,
   output logic                       rd_valid,
   output logic [DataBits-1:0]        rd_data,
   output logic                       rd_perr,
   output logic                       rd_ferr,
   output logic [$clog2(Depth):0]     count,
   output logic                       overflow,
   input  logic                       clr_ovf,
   output logic                       break_det,
   output logic                       RxD_idle
);

   // ---------------------------------------------------------------------------
   // Parameter legality
   // ---------------------------------------------------------------------------
   localparam longint BaudOs = longint'(Baud) * longint'(Oversampling);

   localparam bit ParamsOk =
      (Baud > 0) &&
      (Oversampling >= 8) && ((Oversampling & (Oversampling - 1)) == 0) &&
      (longint'(ClkFrequency) >= BaudOs) &&
      (DataBits >= 5) && (DataBits <= 9) &&
      (Parity >= 0) && (Parity <= 2) &&
      (Depth >= 2) && ((Depth & (Depth - 1)) == 0);

   if (!ParamsOk) begin : g_assertion_error
      $error("uart_rx_fifo: illegal parameter combination");
   end

   // ---------------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------------
   localparam int     AccWidth     = $clog2(ClkFrequency / Baud) + 8;
   localparam int     ShiftLimiter = $clog2(BaudOs >> (31 - AccWidth));
   localparam longint IncL         = ((BaudOs << (AccWidth - ShiftLimiter)) +
                                      (longint'(ClkFrequency) >> (ShiftLimiter + 1))) /
                                     (longint'(ClkFrequency) >> ShiftLimiter);
   localparam logic [AccWidth:0] Inc = (AccWidth + 1)'(IncL);

   localparam int PhW = $clog2(Oversampling);
   localparam logic [PhW-1:0] HalfPh = PhW'(Oversampling / 2 - 1);
   localparam logic [PhW-1:0] LastPh = PhW'(Oversampling - 1);

   localparam int NW = $clog2(DataBits);
   localparam logic [NW-1:0] LastN = NW'(DataBits - 1);

   localparam int IdleMax = 2 * (DataBits + 3) * Oversampling;
   localparam int IW      = $clog2(IdleMax + 1);
   localparam logic [IW-1:0] IdleMaxC = IW'(IdleMax);

   localparam int AW = $clog2(Depth);
   localparam int EW = DataBits + 2;
   localparam logic [AW:0] DepthC = (AW + 1)'(Depth);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
   } state_t;

   // ---------------------------------------------------------------------------
   // Tick generator and input conditioning
   // ---------------------------------------------------------------------------
   logic [AccWidth:0] acc_q, acc_d;
   logic              tick;
   logic [1:0]        sync_q;
   logic [2:0]        filt_q;
   logic              rx_bit;

   // Fractional accumulator: carry out of the low bits is the oversampling tick.
   always_comb begin
      acc_d = {1'b0, acc_q[AccWidth-1:0]} + Inc;
   end

   assign tick   = acc_q[AccWidth];
   assign rx_bit = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);

   // Accumulator, two-flop synchroniser on clk, and 3-sample majority shift on ticks.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge values of the others, independent of statement order.
      if (rst) begin
         acc_q  <= '0;
         sync_q <= 2'b11;
         filt_q <= 3'b111;
      end else begin
         acc_q  <= acc_d;
         sync_q <= {sync_q[0], RxD};
         if (tick) filt_q <= {filt_q[1:0], sync_q[1]};
      end
   end

   // ---------------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [PhW-1:0]      ph_q, ph_d;
   logic [NW-1:0]       n_q, n_d;
   logic [DataBits-1:0] data_q, data_d;
   logic                pbit_q, pbit_d;
   logic [IW-1:0]       idle_q, idle_d;
   logic                wr_q, brk_q;
   logic [EW-1:0]       wr_entry_q;

   logic                bit_smp;
   logic                stop_smp;
   logic                ferr_c, perr_c, brk_c;

   // State register plus the receive datapath and the registered FIFO-write/break strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ph_q       <= '0;
         n_q        <= '0;
         data_q     <= '0;
         pbit_q     <= 1'b0;
         idle_q     <= '0;
         wr_q       <= 1'b0;
         brk_q      <= 1'b0;
         wr_entry_q <= '0;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         n_q        <= n_d;
         data_q     <= data_d;
         pbit_q     <= pbit_d;
         idle_q     <= idle_d;
         wr_q       <= stop_smp;
         brk_q      <= stop_smp & brk_c;
         wr_entry_q <= {ferr_c, perr_c, data_q};
      end
   end

   // Next-state logic: walks start/data/parity/stop on ticks and tracks line idle time.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      ph_d    = ph_q;
      n_d     = n_q;
      data_d  = data_q;
      pbit_d  = pbit_q;
      idle_d  = idle_q;

      unique case (state_q)
         S_IDLE: begin
            if (tick && !rx_bit) begin
               state_d = S_START;
               ph_d    = '0;
            end
         end
         S_START: begin
            if (tick) begin
               if (ph_q == HalfPh) begin
                  if (rx_bit) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     ph_d    = '0;
                     n_d     = '0;
                  end
               end else begin
                  ph_d = ph_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               ph_d = ph_q + 1'b1;
               if (ph_q == LastPh) begin
                  data_d = {rx_bit, data_q[DataBits-1:1]};
                  if (n_q == LastN) state_d = (Parity != 0) ? S_PARITY : S_STOP;
                  else              n_d     = n_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               ph_d = ph_q + 1'b1;
               if (ph_q == LastPh) begin
                  pbit_d  = rx_bit;
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               ph_d = ph_q + 1'b1;
               if (ph_q == LastPh) state_d = brk_c ? S_BRKWAIT : S_IDLE;
            end
         end
         S_BRKWAIT: begin
            if (tick && rx_bit) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q != S_IDLE)                   idle_d = '0;
      else if (tick && (idle_q != IdleMaxC))   idle_d = idle_q + 1'b1;
   end

   // Output decode: sample strobes and the error/break flags of the character in the stop bit.
   always_comb begin
      bit_smp  = tick && (ph_q == LastPh);
      stop_smp = (state_q == S_STOP) && bit_smp;
      ferr_c   = ~rx_bit;
      perr_c   = (Parity != 0) && ((^data_q ^ pbit_q) != (Parity == 1));
      brk_c    = ferr_c && (data_q == '0) && !pbit_q;
   end

   assign break_det = brk_q;
   assign RxD_idle  = (idle_q == IdleMaxC);

   // ---------------------------------------------------------------------------
   // Show-ahead FIFO
   // ---------------------------------------------------------------------------
   logic [EW-1:0] mem_q [Depth];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          do_push, do_pop, drop;
   logic [EW-1:0] head;

   // Push/pop arbitration, exact occupancy and sticky overflow with drop-wins-over-clear.
   always_comb begin
      do_pop  = rd_en && (count_q != '0);
      do_push = wr_q && ((count_q != DepthC) || do_pop);
      drop    = wr_q && (count_q == DepthC) && !do_pop;

      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      ovf_d = ovf_q;
      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   // FIFO control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; occupancy and pointers alone decide
      // which entries are meaningful, and this lets the array map onto RAM.
      if (do_push) mem_q[wr_ptr_q] <= wr_entry_q;
   end

   assign head     = mem_q[rd_ptr_q];
   assign rd_valid = (count_q != '0);
   assign rd_data  = rd_valid ? head[DataBits-1:0] : '0;
   assign rd_perr  = rd_valid & head[DataBits];
   assign rd_ferr  = rd_valid & head[DataBits+1];
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: instance A is 8N1 with a 4-entry FIFO, instance B is 8E1
// with a 16-entry FIFO. 1843200 Hz / 115200 baud x16 gives one tick per clk.
module tb_uart_rx_fifo;

   localparam int ClkHz  = 1843200;
   localparam int BaudR  = 115200;
   localparam int Os     = 16;
   localparam int BitClk = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       rxd_a = 1'b1, rxd_b = 1'b1;
   logic       rd_en_a = 1'b0, rd_en_b = 1'b0;
   logic       clr_a = 1'b0, clr_b = 1'b0;

   logic       a_valid, a_perr, a_ferr, a_ovf, a_brk, a_idle;
   logic [7:0] a_data;
   logic [2:0] a_count;
   logic       b_valid, b_perr, b_ferr, b_ovf, b_brk, b_idle;
   logic [7:0] b_data;
   logic [4:0] b_count;

   uart_rx_fifo #(
      .ClkFrequency(ClkHz), .Baud(BaudR), .Oversampling(Os),
      .DataBits(8), .Parity(0), .Depth(4)
   ) u_dut_a (
      .clk(clk), .rst(rst), .RxD(rxd_a), .rd_en(rd_en_a),
      .rd_valid(a_valid), .rd_data(a_data), .rd_perr(a_perr), .rd_ferr(a_ferr),
      .count(a_count), .overflow(a_ovf), .clr_ovf(clr_a),
      .break_det(a_brk), .RxD_idle(a_idle)
   );

   uart_rx_fifo #(
      .ClkFrequency(ClkHz), .Baud(BaudR), .Oversampling(Os),
      .DataBits(8), .Parity(2), .Depth(16)
   ) u_dut_b (
      .clk(clk), .rst(rst), .RxD(rxd_b), .rd_en(rd_en_b),
      .rd_valid(b_valid), .rd_data(b_data), .rd_perr(b_perr), .rd_ferr(b_ferr),
      .count(b_count), .overflow(b_ovf), .clr_ovf(clr_b),
      .break_det(b_brk), .RxD_idle(b_idle)
   );

   // Selected-instance view (sel=0 -> A, sel=1 -> B)
   logic       sel = 1'b0;
   logic       s_valid, s_perr, s_ferr;
   logic [7:0] s_data;
   logic [4:0] s_count;

   always_comb begin
      s_valid = sel ? b_valid : a_valid;
      s_perr  = sel ? b_perr  : a_perr;
      s_ferr  = sel ? b_ferr  : a_ferr;
      s_data  = sel ? b_data  : a_data;
      s_count = sel ? b_count : {2'b00, a_count};
   end

   int brk_cnt = 0;
   always @(negedge clk) if (a_brk === 1'b1) brk_cnt <= brk_cnt + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_line(input logic v);
      if (sel) rxd_b = v;
      else     rxd_a = v;
   endtask

   // Called on a negedge; drives one full frame plus one idle bit time.
   task automatic send_frame(input logic [7:0] d, input logic has_par,
                             input logic pbit, input logic stop);
      drive_line(1'b0);
      repeat (BitClk) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive_line(d[i]);
         repeat (BitClk) @(negedge clk);
      end
      if (has_par) begin
         drive_line(pbit);
         repeat (BitClk) @(negedge clk);
      end
      drive_line(stop);
      repeat (BitClk) @(negedge clk);
      drive_line(1'b1);
      repeat (BitClk) @(negedge clk);
   endtask

   // Sends a frame and reports how many negedges after the start-bit edge rd_valid was seen.
   task automatic recv_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                             input logic stop, output int lat);
      int l;
      l = -1;
      fork
         send_frame(d, has_par, pbit, stop);
         begin
            for (int i = 1; i <= 240; i++) begin
               @(negedge clk);
               if (s_valid) begin
                  l = i;
                  break;
               end
            end
         end
      join
      lat = l;
   endtask

   task automatic pop_sel();
      if (sel) rd_en_b = 1'b1;
      else     rd_en_a = 1'b1;
      @(negedge clk);
      rd_en_a = 1'b0;
      rd_en_b = 1'b0;
   endtask

   typedef struct {
      logic       sel;
      logic [7:0] data;
      logic       has_par;
      logic       pbit;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int lat_a;
      int dev;
      int brk_before;
      logic ovf_seen;

      vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[9] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

      // Reset state
      repeat (4) @(negedge clk);
      rst = 1'b0;
      check("reset a_valid",    a_valid, 0);
      check("reset a_count",    a_count, 0);
      check("reset a_overflow", a_ovf,   0);
      check("reset a_break",    a_brk,   0);
      check("reset a_idle",     a_idle,  0);
      check("reset b_valid",    b_valid, 0);
      check("reset b_count",    b_count, 0);
      repeat (20) @(negedge clk);

      // Table-driven single frames
      lat_a = 158;
      foreach (vecs[k]) begin
         sel = vecs[k].sel;
         recv_frame(vecs[k].data, vecs[k].has_par, vecs[k].pbit, vecs[k].stop, lat);
         if (k == 0 && lat > 1) lat_a = lat;
         check($sformatf("vec%0d rd_valid", k), s_valid, 1);
         check($sformatf("vec%0d rd_data",  k), s_data,  vecs[k].exp_data);
         check($sformatf("vec%0d rd_perr",  k), s_perr,  vecs[k].exp_perr);
         check($sformatf("vec%0d rd_ferr",  k), s_ferr,  vecs[k].exp_ferr);
         check($sformatf("vec%0d count",    k), s_count, 1);
         pop_sel();
         check($sformatf("vec%0d count after pop", k), s_count, 0);
         check($sformatf("vec%0d valid after pop", k), s_valid, 0);
         repeat (BitClk) @(negedge clk);
      end

      // Empty FIFO with rd_en: no effect
      sel = 1'b0;
      pop_sel();
      check("underflow count", a_count, 0);
      check("underflow valid", a_valid, 0);

      // Short low glitch: rejected as a false start, then idle timer runs again
      rxd_a = 1'b0;
      repeat (4) @(negedge clk);
      rxd_a = 1'b1;
      repeat (200) @(negedge clk);
      check("glitch count",       a_count, 0);
      check("glitch valid",       a_valid, 0);
      check("glitch idle early",  a_idle,  0);
      repeat (200) @(negedge clk);
      check("glitch idle later",  a_idle,  1);
      recv_frame(8'h5A, 1'b0, 1'b0, 1'b1, lat);
      check("post-glitch valid", a_valid, 1);
      check("post-glitch data",  a_data,  8'h5A);
      pop_sel();

      // Break: line low for 40 bit times
      brk_before = brk_cnt;
      rxd_a = 1'b0;
      repeat (40 * BitClk) @(negedge clk);
      rxd_a = 1'b1;
      repeat (100) @(negedge clk);
      check("break pulses",  brk_cnt - brk_before, 1);
      check("break count",   a_count, 1);
      check("break data",    a_data,  8'h00);
      check("break ferr",    a_ferr,  1);
      check("break perr",    a_perr,  0);
      pop_sel();
      recv_frame(8'h11, 1'b0, 1'b0, 1'b1, lat);
      check("post-break data",  a_data,  8'h11);
      check("post-break count", a_count, 1);
      pop_sel();
      repeat (BitClk) @(negedge clk);

      // Overflow on the 4-deep FIFO
      for (int k = 1; k <= 5; k++) recv_frame(8'(k), 1'b0, 1'b0, 1'b1, lat);
      check("ovf count",    a_count, 4);
      check("ovf flag",     a_ovf,   1);
      check("ovf head",     a_data,  8'h01);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("clr_ovf flag",  a_ovf,   0);
      check("clr_ovf count", a_count, 4);

      // Write and pop on the same edge while full
      dev = 0;
      ovf_seen = 1'b0;
      fork
         send_frame(8'h06, 1'b0, 1'b0, 1'b1);
         begin
            repeat (lat_a - 1) @(negedge clk);
            rd_en_a = 1'b1;
            @(negedge clk);
            rd_en_a = 1'b0;
         end
         begin
            for (int i = 0; i < 11 * BitClk; i++) begin
               @(negedge clk);
               if (a_count != 3'd4) dev++;
               if (a_ovf) ovf_seen = 1'b1;
            end
         end
      join
      check("full push+pop count deviations", dev, 0);
      check("full push+pop overflow",         ovf_seen, 0);
      check("full push+pop count",            a_count, 4);
      for (int k = 0; k < 4; k++) begin
         logic [7:0] exp_d;
         exp_d = (k == 3) ? 8'h06 : 8'(k + 2);
         check($sformatf("drain%0d data", k), a_data, exp_d);
         pop_sel();
      end
      check("drained count", a_count, 0);

      // Reset in the middle of the data bits
      fork
         send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
         begin
            repeat (7 * BitClk + 8) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      join
      repeat (32) @(negedge clk);
      check("mid-frame reset count", a_count, 0);
      check("mid-frame reset valid", a_valid, 0);
      recv_frame(8'h96, 1'b0, 1'b0, 1'b1, lat);
      check("post-reset valid", a_valid, 1);
      check("post-reset data",  a_data,  8'h96);
      check("post-reset ferr",  a_ferr,  0);
      pop_sel();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
